// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LAT_CNT_W = 4;
    localparam int WORD_LSB  = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read, no reset.
module dmem_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle MEM-stage responder: accepts one access, stalls the pipeline,
// and completes it LATENCY cycles later with a one-cycle rvalid strobe.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        rvalid,
    output logic        mem_stall,
    output logic        access_err
);

    localparam logic [LAT_CNT_W-1:0] CNT_INIT =
        LAT_CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    state_t                state_q, state_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic                  write_q, err_q;
    logic                  req, req_err, accept, commit;
    logic [31:0]           array_rdata;
    logic                  addr_unused;

    assign req     = mem_read | mem_write;
    assign req_err = (mem_addr[1:0] != 2'b00) | (mem_read & mem_write);
    assign accept  = (state_q == IDLE) & req;

    // Upper address bits are intentionally dropped: addresses wrap modulo depth.
    assign addr_unused = ^mem_addr[31:ADDR_WIDTH+WORD_LSB];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= mem_addr[ADDR_WIDTH+WORD_LSB-1:WORD_LSB];
                wdata_q <= mem_wdata;
                write_q <= mem_write;
                err_q   <= req_err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rvalid     = (state_q == DONE);
    assign access_err = rvalid & err_q;
    assign mem_rdata  = (rvalid & ~write_q & ~err_q) ? array_rdata : 32'h0;
    // DONE drops the stall so the pipeline advances; DONE never samples inputs,
    // so the still-held request is not accepted twice.
    assign mem_stall  = ~reset & (accept | (state_q == BUSY));
    assign commit     = rvalid & write_q & ~err_q & ~reset;

    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .we   (commit),
        .addr (idx_q),
        .wdata(wdata_q),
        .rdata(array_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (LATENCY=3 and LATENCY=1 instances).
module tb_dmem_responder;
    import dmem_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        rd3 = 1'b0, wr3 = 1'b0;
    logic [31:0] a3 = '0, d3 = '0;
    logic [31:0] rdat3;
    logic        rv3, st3, er3;

    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] a1 = '0, d1 = '0;
    logic [31:0] rdat1;
    logic        rv1, st1, er1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(8), .LATENCY(3)) u3 (
        .clk(clk), .reset(reset), .mem_read(rd3), .mem_write(wr3),
        .mem_addr(a3), .mem_wdata(d3), .mem_rdata(rdat3), .rvalid(rv3),
        .mem_stall(st3), .access_err(er3)
    );

    dmem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .mem_read(rd1), .mem_write(wr1),
        .mem_addr(a1), .mem_wdata(d1), .mem_rdata(rdat1), .rvalid(rv1),
        .mem_stall(st1), .access_err(er1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Completions of the LATENCY=3 instance are matched against the scoreboard.
    always @(negedge clk) begin
        if (rv3) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rdata", rdat3, mon_e.rdata);
                chk("access_err", {31'b0, er3}, {31'b0, mon_e.err});
            end
        end
    end

    // Present one request, hold it like a stalled pipeline until rvalid.
    task automatic access3(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] erd,
                           input logic eerr, input bit wiggle);
        int   n;
        int   st;
        exp_t e;
        @(negedge clk);
        rd3 = rd; wr3 = wr; a3 = addr; d3 = wd;
        e.rdata = erd; e.err = eerr;
        sb.push_back(e);
        #1;
        n = 0; st = 0;
        while (!rv3 && n < 40) begin
            if (st3) st++;
            n++;
            @(negedge clk); #1;
            if (wiggle) begin
                a3 = addr ^ 32'h4;
                d3 = ~wd;
            end
        end
        chk("latency", n, 32'd3);
        chk("stall_cycles", st, 32'd3);
    endtask

    initial begin
        bit [5:0] rv_mask;
        bit [5:0] st_mask;
        int       wait_n;

        // Reset: request held high must not raise stall.
        rd3 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_stall", {31'b0, st3}, 32'd0);
        chk("reset_rvalid", {31'b0, rv3}, 32'd0);
        chk("reset_rdata", rdat3, 32'd0);
        chk("reset_err", {31'b0, er3}, 32'd0);
        chk("reset_state", {30'b0, u3.state_q}, {30'b0, IDLE});
        rd3 = 1'b0;
        reset = 1'b0;

        // Store then load.
        access3(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        access3(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

        // Misaligned read.
        access3(1'b0, 1'b1, 32'h20, 32'h600DF00D, 32'h0, 1'b0, 1'b0);
        access3(1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b0);

        // Misaligned write leaves the word untouched.
        access3(1'b0, 1'b1, 32'h22, 32'h1234, 32'h0, 1'b1, 1'b0);
        access3(1'b1, 1'b0, 32'h20, 32'h0, 32'h600DF00D, 1'b0, 1'b0);

        // Read and write together is an error, no array change.
        access3(1'b1, 1'b1, 32'h20, 32'hBAD, 32'h0, 1'b1, 1'b0);
        access3(1'b1, 1'b0, 32'h20, 32'h0, 32'h600DF00D, 1'b0, 1'b0);

        // Inputs changing during BUSY are ignored.
        access3(1'b0, 1'b1, 32'h80, 32'h77, 32'h0, 1'b0, 1'b1);
        access3(1'b1, 1'b0, 32'h80, 32'h0, 32'h77, 1'b0, 1'b0);
        access3(1'b1, 1'b0, 32'h84, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset in BUSY drops the pending store.
        access3(1'b0, 1'b1, 32'h40, 32'h11111111, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rd3 = 1'b0; wr3 = 1'b1; a3 = 32'h40; d3 = 32'hCAFEF00D;
        @(negedge clk); #1;
        chk("pre_reset_state", {30'b0, u3.state_q}, {30'b0, BUSY});
        chk("pre_reset_stall", {31'b0, st3}, 32'd1);
        reset = 1'b1; wr3 = 1'b0;
        @(negedge clk); #1;
        chk("post_reset_state", {30'b0, u3.state_q}, {30'b0, IDLE});
        chk("post_reset_rvalid", {31'b0, rv3}, 32'd0);
        chk("post_reset_stall", {31'b0, st3}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("idle_after_reset", {31'b0, rv3}, 32'd0);
        end
        access3(1'b1, 1'b0, 32'h40, 32'h0, 32'h11111111, 1'b0, 1'b0);

        // Address wrap and boundary words.
        access3(1'b0, 1'b1, 32'h400, 32'h55, 32'h0, 1'b0, 1'b0);
        access3(1'b1, 1'b0, 32'h0, 32'h0, 32'h55, 1'b0, 1'b0);
        access3(1'b0, 1'b1, 32'h3FC, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
        access3(1'b1, 1'b0, 32'h3FC, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
        access3(1'b1, 1'b0, 32'h0, 32'h0, 32'h55, 1'b0, 1'b0);
        @(negedge clk);
        rd3 = 1'b0; wr3 = 1'b0;

        // LATENCY=1: store, then two back-to-back loads held by the pipeline.
        @(negedge clk);
        wr1 = 1'b1; a1 = 32'h8; d1 = 32'h1357;
        #1;
        chk("l1_store_stall", {31'b0, st1}, 32'd1);
        @(negedge clk); #1;
        chk("l1_store_rvalid", {31'b0, rv1}, 32'd1);
        chk("l1_store_err", {31'b0, er1}, 32'd0);
        wr1 = 1'b0;
        @(negedge clk);
        rd1 = 1'b1; a1 = 32'h8;
        #1;
        rv_mask = '0; st_mask = '0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(negedge clk); #1;
            end
            rv_mask[i] = rv1;
            st_mask[i] = st1;
            if (rv1) chk("l1_load_rdata", rdat1, 32'h1357);
            if (i == 3) rd1 = 1'b0;
        end
        chk("l1_rvalid_pattern", {26'b0, rv_mask}, 32'b001010);
        chk("l1_stall_pattern", {26'b0, st_mask}, 32'b000101);

        wait_n = 0;
        while (sb.size() != 0 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
